// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI-Lite byte-memory slave.
// No ports; imported by the interface, the storage array and the slave FSM.
package axi_lite_pkg;

  localparam int ADDR_WIDTH  = 12;
  localparam int DATA_WIDTH  = 8;
  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int BUFFER_SIZE = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WDATA,
    WRESP
  } state_type;

  // True when the byte address is backed by storage.
  function automatic logic addr_in_range(input addr_t addr, input int unsigned depth);
    return int'(addr) < int'(depth);
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI-Lite bus bundle (five channels) between a master and the memory slave.
// Ports: none; signals are grouped into master and slave modports.
interface axi_lite_mem_slave_if;
  import axi_lite_pkg::*;

  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;
  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_lite_mem.sv
// Byte storage array: MEM_DEPTH x DATA_WIDTH, synchronous write, combinational read.
// Ports: clk_i, we_i, waddr_i, wdata_i (write side); raddr_i, rdata_o (read side).
// Contents are never reset.
module axi_lite_mem
  import axi_lite_pkg::*;
#(
  parameter  int MEM_DEPTH = 2048,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  data_t            wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output data_t            rdata_o
);

  data_t mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite slave in front of a byte memory; one transaction outstanding at a time.
// Ports: aclk, areset (sync, active-high), s (slave modport of the AXI-Lite bundle).
// Addresses at or above MEM_DEPTH answer SLVERR, read 0 and never touch storage.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter  int MEM_DEPTH = 2048,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_lite_mem_slave_if.slave   s
);

  state_type state_q;
  addr_t     addr_q;
  logic      last_was_read_q;
  logic      arready_q, awready_q, wready_q, rvalid_q, bvalid_q;
  data_t     rdata_q;
  resp_t     rresp_q, bresp_q;

  data_t     mem_rdata;
  logic      mem_we;
  logic      rd_in_range, wr_in_range;

  assign rd_in_range = addr_in_range(s.araddr, MEM_DEPTH);
  assign wr_in_range = addr_in_range(addr_q, MEM_DEPTH);

  // Gated by areset so a reset landing on the data handshake leaves storage alone.
  assign mem_we = (state_q == WDATA) && wready_q && s.wvalid && s.wstrb[0]
                  && wr_in_range && !areset;

  axi_lite_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk_i   (aclk),
    .we_i    (mem_we),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (s.wdata),
    .raddr_i (s.araddr[IDX_W-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      last_was_read_q <= 1'b0;
      arready_q       <= 1'b0;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      rvalid_q        <= 1'b0;
      bvalid_q        <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= RESP_OKAY;
      bresp_q         <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the channel not served last wins.
          if (s.arvalid && (!s.awvalid || !last_was_read_q)) begin
            state_q         <= RADDR;
            arready_q       <= 1'b1;
            last_was_read_q <= 1'b1;
          end else if (s.awvalid) begin
            state_q         <= WADDR;
            awready_q       <= 1'b1;
            last_was_read_q <= 1'b0;
          end
        end
        RADDR: begin
          arready_q <= 1'b0;
          addr_q    <= s.araddr;
          rvalid_q  <= 1'b1;
          if (rd_in_range) begin
            rdata_q <= mem_rdata;
            rresp_q <= RESP_OKAY;
          end else begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
          end
          state_q <= RDATA;
        end
        RDATA: begin
          if (s.rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WADDR: begin
          awready_q <= 1'b0;
          addr_q    <= s.awaddr;
          wready_q  <= 1'b1;
          state_q   <= WDATA;
        end
        WDATA: begin
          if (s.wvalid) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (s.bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s.arready = arready_q;
  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;

endmodule
